mem_io_responder: RTL and testbench

MEM_IO_RESPONDER -- requirements
Module: mem_io_responder

---
 rtl/mem_io_responder.sv | 118 +++++++++++
 tb/tb_mem_io_responder.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_io_responder.sv
// CPU-side memory/I-O responder: byte RAM, a buffered output port and a single-byte input port,
// all sharing one tri-state data bus.
module mem_io_responder #(
   parameter int unsigned MEM_DEPTH   = 256,
   parameter int unsigned OFIFO_DEPTH = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] addr_bus,
   input  logic       c_ri,
   input  logic       c_ro,
   input  logic       mem_clk,
   input  logic       mem_io,
   inout  wire  [7:0] bus,
   output logic [7:0] out_data,
   output logic       out_valid,
   input  logic       out_ready,
   input  logic [7:0] in_data,
   input  logic       in_valid,
   output logic       in_ready,
   output logic       out_overflow
);

   localparam int unsigned AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
   localparam int unsigned PW = $clog2(OFIFO_DEPTH);

   logic [7:0]    mem [MEM_DEPTH];
   logic [7:0]    fifo_mem [OFIFO_DEPTH];

   logic [AW-1:0] mem_idx;
   logic [7:0]    rdata_q;
   logic          rd_valid_q;
   logic [7:0]    hold_q;
   logic          in_full_q;
   logic [PW-1:0] wr_ptr_q, rd_ptr_q;
   logic [PW:0]   count_q;
   logic          overflow_q;

   logic ram_wr, rd_req, ram_rd, in_consume, in_capture;
   logic push_req, push_ok, pop, fifo_full;

   assign mem_idx = AW'(32'(addr_bus) % MEM_DEPTH);

   always_comb begin
      ram_wr     = mem_clk && c_ri && !mem_io;
      // A pending read is not reloaded while the previous one is still on the bus.
      rd_req     = mem_clk && c_ro && !c_ri && !rd_valid_q;
      ram_rd     = rd_req && !mem_io;
      in_consume = rd_req && mem_io && in_full_q;
      in_capture = in_valid && !in_full_q;
      fifo_full  = (count_q == (PW+1)'(OFIFO_DEPTH));
      pop        = out_valid && out_ready;
      push_req   = mem_clk && c_ri && mem_io;
      // A pop on the same edge frees the slot, so a full FIFO still accepts the push.
      push_ok    = push_req && (!fifo_full || pop);
   end

   assign bus          = (rd_valid_q && c_ro && !c_ri) ? rdata_q : 8'hzz;
   assign out_valid    = (count_q != '0);
   assign out_data     = fifo_mem[rd_ptr_q];
   assign in_ready     = !in_full_q;
   assign out_overflow = overflow_q;

   // Storage arrays are never reset; reset only blocks writes on its edge.
   always_ff @(posedge clk) begin
      if (!reset && ram_wr) begin
         mem[mem_idx] <= bus;
      end
      if (!reset && push_ok) begin
         fifo_mem[wr_ptr_q] <= bus;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_valid_q <= 1'b0;
         in_full_q  <= 1'b0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         if (!c_ro) begin
            rd_valid_q <= 1'b0;
         end else if (ram_rd) begin
            rd_valid_q <= 1'b1;
            rdata_q    <= mem[mem_idx];
         end else if (in_consume) begin
            rd_valid_q <= 1'b1;
            rdata_q    <= hold_q;
         end

         if (in_consume) begin
            in_full_q <= 1'b0;
         end else if (in_capture) begin
            in_full_q <= 1'b1;
            hold_q    <= in_data;
         end

         if (push_ok) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         unique case ({push_ok, pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase

         if (push_req && !push_ok) begin
            overflow_q <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_mem_io_responder.sv
// Directed bench for mem_io_responder; the bus has a pull-up so an undriven bus reads 8'hFF.
module tb_mem_io_responder;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] addr_bus;
   logic       c_ri, c_ro, mem_clk, mem_io;
   tri1  [7:0] bus;
   logic [7:0] out_data;
   logic       out_valid, out_ready;
   logic [7:0] in_data;
   logic       in_valid, in_ready, out_overflow;

   logic [7:0] drv;
   logic       drv_en;

   int total = 0;
   int bad   = 0;

   assign bus = drv_en ? drv : 8'hzz;

   always #5 clk = ~clk;

   mem_io_responder #(.MEM_DEPTH(256), .OFIFO_DEPTH(4)) dut (
      .clk          (clk),
      .reset        (reset),
      .addr_bus     (addr_bus),
      .c_ri         (c_ri),
      .c_ro         (c_ro),
      .mem_clk      (mem_clk),
      .mem_io       (mem_io),
      .bus          (bus),
      .out_data     (out_data),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .in_data      (in_data),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .out_overflow (out_overflow)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      mem_clk = 1'b0;
      c_ri    = 1'b0;
      c_ro    = 1'b0;
      drv_en  = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      idle();
      mem_io = 1'b0; addr_bus = 8'h00; out_ready = 1'b0;
      in_valid = 1'b0; in_data = 8'h00; drv = 8'h00;
      step(); step();
      reset = 1'b0;
      step();
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
      total++; if (out_overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow got=%b want=0", out_overflow); end
      total++; if (bus !== 8'hff) begin bad++; $display("FAIL reset_bus_z got=%h want=ff", bus); end
   endtask

   task automatic test_ram();
      addr_bus = 8'h10; mem_io = 1'b0; c_ri = 1'b1; drv = 8'h5a; drv_en = 1'b1; mem_clk = 1'b1;
      step();
      idle();
      c_ro = 1'b1; mem_clk = 1'b1;
      step();
      total++; if (bus !== 8'h5a) begin bad++; $display("FAIL ram_read got=%h want=5a", bus); end
      mem_clk = 1'b0;
      step();
      total++; if (bus !== 8'h5a) begin bad++; $display("FAIL ram_read_hold got=%h want=5a", bus); end
      c_ro = 1'b0;
      #1;
      total++; if (bus !== 8'hff) begin bad++; $display("FAIL ram_release got=%h want=ff", bus); end
      step();
   endtask

   task automatic test_rw_both();
      addr_bus = 8'h20; mem_io = 1'b0; c_ri = 1'b1; c_ro = 1'b1;
      drv = 8'h33; drv_en = 1'b1; mem_clk = 1'b1;
      step();
      mem_clk = 1'b0; drv_en = 1'b0;
      step();
      total++; if (bus !== 8'hff) begin bad++; $display("FAIL rw_no_drive got=%h want=ff", bus); end
      idle();
      step();
      c_ro = 1'b1; mem_clk = 1'b1;
      step();
      total++; if (bus !== 8'h33) begin bad++; $display("FAIL rw_readback got=%h want=33", bus); end
      idle();
      step();
      addr_bus = 8'h10; c_ro = 1'b1; mem_clk = 1'b1;
      step();
      total++; if (bus !== 8'h5a) begin bad++; $display("FAIL ram_other_addr got=%h want=5a", bus); end
      idle();
      step();
   endtask

   task automatic test_out_fifo();
      logic [7:0] exp;
      out_ready = 1'b0; mem_io = 1'b1; c_ri = 1'b1; drv_en = 1'b1; mem_clk = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         drv = 8'(i);
         step();
      end
      idle();
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL fifo_valid got=%b want=1", out_valid); end
      total++; if (out_overflow !== 1'b1) begin bad++; $display("FAIL fifo_overflow got=%b want=1", out_overflow); end
      out_ready = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         exp = 8'(i);
         total++; if (out_data !== exp) begin bad++; $display("FAIL fifo_order got=%h want=%h", out_data, exp); end
         step();
      end
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL fifo_drained got=%b want=0", out_valid); end
      out_ready = 1'b0;
      step();
      total++; if (out_overflow !== 1'b1) begin bad++; $display("FAIL overflow_sticky got=%b want=1", out_overflow); end

      // Fill, then push and pop on the same edge while full.
      mem_io = 1'b1; c_ri = 1'b1; drv_en = 1'b1; mem_clk = 1'b1;
      for (int i = 0; i < 4; i++) begin
         drv = 8'h11 + 8'(i);
         step();
      end
      out_ready = 1'b1; drv = 8'h15;
      step();
      idle();
      for (int i = 0; i < 4; i++) begin
         exp = 8'h12 + 8'(i);
         total++; if (out_data !== exp) begin bad++; $display("FAIL fifo_full_pushpop got=%h want=%h", out_data, exp); end
         total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL fifo_full_valid got=%b want=1", out_valid); end
         step();
      end
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL fifo_full_drained got=%b want=0", out_valid); end
      out_ready = 1'b0;
   endtask

   task automatic test_in_port();
      mem_io = 1'b1; c_ro = 1'b1; mem_clk = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         total++; if (bus !== 8'hff) begin bad++; $display("FAIL in_wait_z got=%h want=ff", bus); end
      end
      mem_clk = 1'b0; in_valid = 1'b1; in_data = 8'ha7;
      step();
      in_valid = 1'b0;
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL in_full got=%b want=0", in_ready); end
      total++; if (bus !== 8'hff) begin bad++; $display("FAIL in_not_yet got=%h want=ff", bus); end
      mem_clk = 1'b1;
      step();
      total++; if (bus !== 8'ha7) begin bad++; $display("FAIL in_read got=%h want=a7", bus); end
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL in_consumed got=%b want=1", in_ready); end
      // A new byte arrives while the previous read is still held: no reload, no consume.
      in_valid = 1'b1; in_data = 8'h3c;
      step();
      in_valid = 1'b0;
      step();
      total++; if (bus !== 8'ha7) begin bad++; $display("FAIL in_no_reload got=%h want=a7", bus); end
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL in_no_consume got=%b want=0", in_ready); end
      c_ro = 1'b0; mem_clk = 1'b0;
      step();
      c_ro = 1'b1; mem_clk = 1'b1;
      step();
      total++; if (bus !== 8'h3c) begin bad++; $display("FAIL in_second got=%h want=3c", bus); end
      idle();
      step();
   endtask

   task automatic test_reset_mid();
      out_ready = 1'b0; mem_io = 1'b1; c_ri = 1'b1; drv_en = 1'b1; mem_clk = 1'b1;
      drv = 8'h61; step();
      drv = 8'h62; step();
      idle();
      mem_io = 1'b0; addr_bus = 8'h10; c_ro = 1'b1; mem_clk = 1'b1;
      step();
      mem_clk = 1'b0;
      total++; if (bus !== 8'h5a) begin bad++; $display("FAIL pre_reset_bus got=%h want=5a", bus); end
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL pre_reset_valid got=%b want=1", out_valid); end
      // Reset with a concurrent read strobe still pending.
      reset = 1'b1; mem_clk = 1'b1;
      step();
      total++; if (bus !== 8'hff) begin bad++; $display("FAIL reset_mid_bus got=%h want=ff", bus); end
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_mid_valid got=%b want=0", out_valid); end
      total++; if (out_overflow !== 1'b0) begin bad++; $display("FAIL reset_mid_ovf got=%b want=0", out_overflow); end
      reset = 1'b0; mem_clk = 1'b0;
      step();
      total++; if (bus !== 8'hff) begin bad++; $display("FAIL post_reset_bus got=%h want=ff", bus); end
      c_ro = 1'b0;
      step();
      c_ro = 1'b1; mem_clk = 1'b1;
      step();
      total++; if (bus !== 8'h5a) begin bad++; $display("FAIL ram_survives_reset got=%h want=5a", bus); end
      idle();
      step();
   endtask

   initial begin
      test_reset();
      test_ram();
      test_rw_both();
      test_out_fifo();
      test_in_port();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
